fp_div_seq: RTL and testbench
=============================

# fp_div_seq

Sequential IEEE-754 single-precision divider, the inverse companion to the team's combinational floating-point multiplier. It computes Q = A / B with a 25-cycle restoring mantissa divider and a one-cycle normalise stage. It uses the same simplified number model as the multiplier: no denormals, no NaN handling, and a truncated mantissa. A start/busy/done handshake lets a controller share it with the multiplier datapath.

## Interface
- No parameters; the format is fixed at 32-bit single precision: 1 sign bit, 8 exponent bits with bias 127, 23 mantissa bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low; clears all state.
- start  in  1  request pulse; sampled only in IDLE.
- A  in  32  dividend; captured when start is accepted.
- B  in  32  divisor; captured when start is accepted.
- busy  out  1  high while a division is in progress (DIV or NORM state).
- done  out  1  one-cycle pulse; Q and the flags are valid and held until the next accepted start.
- Q  out  32  quotient.
- underflow  out  1  biased result exponent is ≤ 0; Q is forced to signed zero.
- overflow  out  1  biased result exponent is ≥ 255; Q is forced to signed infinity.
- div_by_zero  out  1  B exponent field is 0; Q is forced to signed infinity.

## Operation
- States and transitions:
  - IDLE: start=1 → DIV, or → IDLE with done if a special case applies.
  - DIV: 25 iterations → NORM.
  - NORM → IDLE, asserting done.
- On accept, register the operands and compute:
  - sign = A[31]^B[31].
  - e = A[30:23] − B[30:23] + 127, as a 10-bit signed value.
  - dividend a = {1,A[22:0]}, divisor b = {1,B[22:0]}, both 24-bit.
  - R (25-bit) = a, quotient register q cleared, iteration counter = 24.
- Special cases are resolved in IDLE on the accept edge and bypass DIV/NORM:
  - B[30:23]==0: div_by_zero=1, Q={sign,8'hFF,23'b0}. This takes priority.
  - Else A[30:23]==0: Q={sign,31'b0}, no flags.
- Each DIV cycle:
  - If R ≥ b, shift in q bit 1 and set R = R−b; else shift in 0.
  - Then R = R<<1 and the counter decrements.
  - After 25 cycles q[24:0] holds a/b with q[24] of weight 2^0.
- NORM:
  - If q[24]=1: mantissa = q[23:1] and e is unchanged.
  - Else: mantissa = q[22:0] and e = e−1.
  - Round by truncation; the remainder is discarded.
  - e ≤ 0: underflow=1, Q={sign,31'b0}.
  - e ≥ 255: overflow=1, Q={sign,8'hFF,23'b0}.
  - Otherwise Q={sign,e[7:0],mantissa}.
- All three flags clear on every accepted start and update together with Q.
- start while busy=1 is ignored; the operands are not re-captured.

## Timing
- Reset values:
  - Q=0, busy=0, done=0, underflow=0, overflow=0, div_by_zero=0.
  - State=IDLE, counter=0.
- Normal latency, with start accepted at edge k:
  - busy=1 after edge k.
  - DIV occupies edges k+1..k+25.
  - NORM registers Q and the flags at edge k+26; done=1 and busy=0 after edge k+26 for exactly one cycle.
- Special-case latency: Q, the flags and done update at the accept edge k. busy stays 0.
- Back-to-back operation: start may be high in the same cycle done is high (state is IDLE), so the next operation is accepted at that edge. In that case done drops the following cycle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously), and the in-flight result is lost. No done is produced for it.

## Test plan
- 6.0/2.0: A=0x40C00000, B=0x40000000, start at edge k → done at k+26 with Q=0x40400000 and all flags 0. busy is high for 26 cycles.
- 1.0/3.0: A=0x3F800000, B=0x40400000 → Q=0x3EAAAAAA (normalise-shift path, truncated). Then −7.5/2.5: A=0xC0F00000, B=0x40200000 → Q=0xC0400000.
- Special cases:
  - A=0x3F800000, B=0x00000000 → div_by_zero=1, Q=0x7F800000, done one edge after start, busy never high.
  - A=0x80000000, B=0x40000000 → Q=0x80000000.
- Range:
  - A=0x7F000000, B=0x3E800000 → overflow=1, Q=0x7F800000.
  - A=0x00800000, B=0x40000000 → underflow=1, Q=0x00000000.
  - A flag set by one operation clears on the next accepted start.
- Handshake and reset:
  - Pulse start again at k+5 with different operands → ignored; the result still equals the first operation at k+26.
  - Deassert rst_n at k+10 → all outputs 0 immediately, no done. A fresh start after release produces a correct result 26 cycles later.

Source files
------------

// File: rtl/fp_div_seq_if.sv
// Handshake/operand bundle between a controller and the sequential FP32 divider.
interface fp_div_seq_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic        underflow;
    logic        overflow;
    logic        div_by_zero;

    modport master (
        output start, A, B,
        input  busy, done, Q, underflow, overflow, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, underflow, overflow, div_by_zero
    );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential FP32 divider: 25-cycle restoring mantissa divide plus one normalise cycle.
// Simplified number model: no denormals/NaN, truncated mantissa.
module fp_div_seq (
    input  logic         clk,
    input  logic         rst_n,
    fp_div_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [24:0] rem;
    logic [24:0] quo;
    logic [23:0] dvs;
    logic [9:0]  exp_r;
    logic        sign_r;
    logic [31:0] q_r;
    logic        done_r, uf_r, of_r, dz_r;

    logic        a_zero, b_zero, special, ge;
    logic [24:0] rem_sel;
    logic [9:0]  exp_in, exp_n;
    logic [22:0] man_n;
    logic        in_sign;

    assign a_zero  = (bus.A[30:23] == 8'd0);
    assign b_zero  = (bus.B[30:23] == 8'd0);
    assign special = a_zero | b_zero;
    assign in_sign = bus.A[31] ^ bus.B[31];
    // Biased exponent difference; 10 bits two's complement covers -127..382
    assign exp_in  = {2'b00, bus.A[30:23]} - {2'b00, bus.B[30:23]} + 10'd127;

    assign ge      = (rem >= {1'b0, dvs});
    assign rem_sel = ge ? (rem - {1'b0, dvs}) : rem;

    assign exp_n   = quo[24] ? exp_r : (exp_r - 10'd1);
    assign man_n   = quo[24] ? quo[23:1] : quo[22:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !special) state_nxt = DIV;
            DIV:     if (cnt == 5'd0) state_nxt = NORM;
            NORM:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            exp_r  <= '0;
            sign_r <= 1'b0;
            q_r    <= '0;
            done_r <= 1'b0;
            uf_r   <= 1'b0;
            of_r   <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    uf_r   <= 1'b0;
                    of_r   <= 1'b0;
                    dz_r   <= 1'b0;
                    sign_r <= in_sign;
                    exp_r  <= exp_in;
                    dvs    <= {1'b1, bus.B[22:0]};
                    rem    <= {2'b01, bus.A[22:0]};
                    quo    <= '0;
                    cnt    <= 5'd24;
                    // Zero divisor wins over zero dividend
                    if (b_zero) begin
                        dz_r   <= 1'b1;
                        q_r    <= {in_sign, 8'hFF, 23'd0};
                        done_r <= 1'b1;
                    end else if (a_zero) begin
                        q_r    <= {in_sign, 31'd0};
                        done_r <= 1'b1;
                    end
                end
                DIV: begin
                    quo <= {quo[23:0], ge};
                    rem <= {rem_sel[23:0], 1'b0};
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                NORM: begin
                    done_r <= 1'b1;
                    if (exp_n[9] || exp_n == 10'd0) begin
                        uf_r <= 1'b1;
                        q_r  <= {sign_r, 31'd0};
                    end else if (exp_n >= 10'd255) begin
                        of_r <= 1'b1;
                        q_r  <= {sign_r, 8'hFF, 23'd0};
                    end else begin
                        q_r  <= {sign_r, exp_n[7:0], man_n};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state == DIV) || (state == NORM);
    assign bus.done        = done_r;
    assign bus.Q           = q_r;
    assign bus.underflow   = uf_r;
    assign bus.overflow    = of_r;
    assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: results, flags, latency, handshake and async reset.
module tb_fp_div_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fp_div_seq_if bus ();

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns edges until done is seen (bounded) and the number of busy samples.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) bc++;
        end
    endtask

    function automatic logic [2:0] flags();
        return {bus.underflow, bus.overflow, bus.div_by_zero};
    endfunction

    initial begin
        int lat, bc, seen;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        #1;
        chk("reset_q", bus.Q, 32'h0);
        chk("reset_ctl", {27'd0, bus.busy, bus.done, flags()}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 6.0 / 2.0
        op_start(32'h40C00000, 32'h40000000);
        wait_done(lat, bc);
        chk("6/2_lat", lat, 26);
        chk("6/2_busy_cycles", bc, 26);
        chk("6/2_q", bus.Q, 32'h40400000);
        chk("6/2_flags", {29'd0, flags()}, 32'h0);

        // 1.0 / 3.0 accepted back-to-back in the done cycle
        op_start(32'h3F800000, 32'h40400000);
        chk("b2b_done_drop", {31'd0, bus.done}, 32'h0);
        chk("b2b_busy", {31'd0, bus.busy}, 32'h1);
        wait_done(lat, bc);
        chk("1/3_lat", lat, 26);
        chk("1/3_q", bus.Q, 32'h3EAAAAAA);

        // -7.5 / 2.5
        op_start(32'hC0F00000, 32'h40200000);
        wait_done(lat, bc);
        chk("m7.5/2.5_q", bus.Q, 32'hC0400000);

        // divide by zero
        op_start(32'h3F800000, 32'h00000000);
        chk("dz_done", {31'd0, bus.done}, 32'h1);
        chk("dz_busy", {31'd0, bus.busy}, 32'h0);
        chk("dz_q", bus.Q, 32'h7F800000);
        chk("dz_flags", {29'd0, flags()}, 32'h1);
        @(posedge clk);
        #1;
        chk("dz_done_pulse", {31'd0, bus.done}, 32'h0);

        // zero dividend
        op_start(32'h80000000, 32'h40000000);
        chk("zero_done", {31'd0, bus.done}, 32'h1);
        chk("zero_q", bus.Q, 32'h80000000);
        chk("zero_flags", {29'd0, flags()}, 32'h0);

        // overflow
        op_start(32'h7F000000, 32'h3E800000);
        wait_done(lat, bc);
        chk("ovf_q", bus.Q, 32'h7F800000);
        chk("ovf_flags", {29'd0, flags()}, 32'h2);

        // flag clears on next accept
        op_start(32'h40C00000, 32'h40000000);
        chk("ovf_clear", {31'd0, bus.overflow}, 32'h0);
        wait_done(lat, bc);

        // underflow
        op_start(32'h00800000, 32'h40000000);
        wait_done(lat, bc);
        chk("udf_q", bus.Q, 32'h00000000);
        chk("udf_flags", {29'd0, flags()}, 32'h4);

        // start while busy is ignored
        op_start(32'h40C00000, 32'h40000000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.A     = 32'h3F800000;
        bus.B     = 32'h40400000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, bc);
        chk("ign_lat", lat, 21);
        chk("ign_q", bus.Q, 32'h40400000);

        // async reset mid-operation
        op_start(32'hC0F00000, 32'h40200000);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_q", bus.Q, 32'h0);
        chk("rst_mid_ctl", {27'd0, bus.busy, bus.done, flags()}, 32'h0);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1;
        end
        chk("rst_no_done", seen, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op_start(32'h3F800000, 32'h40400000);
        wait_done(lat, bc);
        chk("post_rst_lat", lat, 26);
        chk("post_rst_q", bus.Q, 32'h3EAAAAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
